cb_rc_gen: RTL and testbench
============================

CB_RC_GEN -- requirements
Module: cb_rc_gen

Interface
REQ-001 SHALL have parameter ROW_LEN, default 10, meaning the width of the row/col index.
REQ-002 SHALL have parameter MAX_LANDMARK, default 500, meaning matrix dimension DIM = 2*MAX_LANDMARK+3 = 1003.
REQ-003 SHALL have parameter AGD_LAT, default 5, meaning the cycles from CB_row/CB_col to CB_base_addr in the downstream address generator.
REQ-004 clk  in  1  the single clock; all logic on its rising edge.
REQ-005 sys_rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  block request valid.
REQ-007 req_ready  out  1  block request accepted when req_valid && req_ready.
REQ-008 req_row, req_col  in  ROW_LEN each  start row and start col of the block.
REQ-009 req_nrow, req_ncol  in  ROW_LEN each  block height and width.
REQ-010 hold  in  1  stall; while high, no beat issues.
REQ-011 CB_row, CB_col  out  ROW_LEN each  element index driven to the address generator.
REQ-012 rc_valid  out  1  CB_row/CB_col carry a beat this cycle.
REQ-013 addr_valid, addr_last  out  1 each  rc_valid and last-beat flag, delayed AGD_LAT cycles, aligned with CB_base_addr.
REQ-014 done  out  1  one-cycle pulse when the request completes.
REQ-015 req_err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DRAIN; req_ready SHALL equal (state==IDLE).
REQ-017 IDLE SHALL move to RUN on handshake when req_nrow!=0, req_ncol!=0, req_row+req_nrow<=DIM and req_col+req_ncol<=DIM, with sums computed at ROW_LEN+1 bits.
REQ-018 On a handshake with req_row+req_nrow>DIM or req_col+req_ncol>DIM, SHALL pulse req_err the next cycle and stay in IDLE with no beats.
REQ-019 On a handshake with a valid range but req_nrow==0 or req_ncol==0, SHALL pulse done the next cycle and stay in IDLE with no beats.
REQ-020 In RUN, SHALL issue one beat per cycle while hold==0, in row-major order: col steps from req_col to req_col+req_ncol-1, then row increments and col returns to req_col.
REQ-021 The first beat SHALL appear the cycle after the handshake, giving req_nrow*req_ncol beats in total.
REQ-022 While hold==1, SHALL keep rc_valid=0 and hold CB_row/CB_col and the counters unchanged.
REQ-023 After the final beat, SHALL go to DRAIN, stay AGD_LAT cycles, then return to IDLE.
REQ-024 SHALL pulse done in the same cycle as the addr_valid carrying addr_last=1.
REQ-025 addr_valid/addr_last SHALL be the rc_valid/last-beat values passed through an AGD_LAT-stage shift register that shifts every cycle, independent of hold.
REQ-026 SHALL ignore req_valid outside IDLE; a request held through RUN/DRAIN SHALL be accepted on the first IDLE cycle.

Reset
REQ-027 On sys_rst, SHALL set state=IDLE and clear the counters and delay line.
REQ-028 Reset values SHALL be: CB_row=0, CB_col=0, rc_valid=0, addr_valid=0, addr_last=0, done=0, req_err=0, req_ready=0 during the reset cycle and 1 after.
REQ-029 Reset during RUN or DRAIN SHALL abort the request with no done and no further addr_valid.

Configuration
REQ-030 Macro CB_SYM_SWAP_EN: when defined, a beat with col>row SHALL drive CB_row=col and CB_col=row, so only the lower-triangular storage is addressed; when undefined, CB_row/CB_col SHALL equal the raw traversal indices.

Verification
REQ-031 row=8, col=0, nrow=2, ncol=3, hold=0 -> beats (8,0)(8,1)(8,2)(9,0)(9,1)(9,2) on cycles 1..6, addr_valid on cycles 6..11, addr_last and done on cycle 11.
REQ-032 Same request with hold=1 on cycles 2..3 -> beat (8,1) on cycle 4, sequence otherwise unchanged, done on cycle 13.
REQ-033 row=1000, nrow=4 -> req_err pulse, no rc_valid; row=1000, nrow=3, ncol=1 -> 3 beats and done.
REQ-034 nrow=0 -> done pulse one cycle after the handshake, no beats.
REQ-035 sys_rst asserted on the 3rd beat of a 2x3 request -> no further rc_valid, addr_valid or done; req_ready=1 after reset.
REQ-036 With CB_SYM_SWAP_EN, row=2, col=5, nrow=1, ncol=1 -> CB_row=5, CB_col=2; without it -> CB_row=2, CB_col=5.

Source files
------------

// File: rtl/cb_rc_gen_if.sv
// Request/beat bundle between a block requester and cb_rc_gen.
// The master drives requests and stall; the slave (generator) drives beats and status.
interface cb_rc_gen_if #(
    parameter int ROW_LEN = 10
);
    logic               req_valid;
    logic               req_ready;
    logic [ROW_LEN-1:0] req_row;
    logic [ROW_LEN-1:0] req_col;
    logic [ROW_LEN-1:0] req_nrow;
    logic [ROW_LEN-1:0] req_ncol;
    logic               hold;
    logic [ROW_LEN-1:0] CB_row;
    logic [ROW_LEN-1:0] CB_col;
    logic               rc_valid;
    logic               addr_valid;
    logic               addr_last;
    logic               done;
    logic               req_err;

    modport master (
        output req_valid, req_row, req_col, req_nrow, req_ncol, hold,
        input  req_ready, CB_row, CB_col, rc_valid, addr_valid, addr_last, done, req_err
    );

    modport slave (
        input  req_valid, req_row, req_col, req_nrow, req_ncol, hold,
        output req_ready, CB_row, CB_col, rc_valid, addr_valid, addr_last, done, req_err
    );
endinterface

// File: rtl/cb_rc_gen.sv
// Row-major block index generator feeding a fixed-latency address generator.
// Optional CB_SYM_SWAP_EN folds upper-triangular beats onto the lower triangle.
module cb_rc_gen #(
    parameter int ROW_LEN      = 10,
    parameter int MAX_LANDMARK = 500,
    parameter int AGD_LAT      = 5
) (
    input logic        clk,
    input logic        sys_rst,
    cb_rc_gen_if.slave bus
);
    localparam int                DIM        = 2 * MAX_LANDMARK + 3;
    localparam logic [ROW_LEN:0]  DIM_W      = (ROW_LEN + 1)'(DIM);
    localparam int                CW         = $clog2(AGD_LAT + 1);
    localparam logic [CW-1:0]     DRAIN_LAST = CW'(AGD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q, state_d;
    logic [ROW_LEN-1:0] row_q, row_d;
    logic [ROW_LEN-1:0] col_q, col_d;
    logic [ROW_LEN-1:0] col_first_q, col_first_d;
    logic [ROW_LEN-1:0] row_last_q, row_last_d;
    logic [ROW_LEN-1:0] col_last_q, col_last_d;
    logic [CW-1:0]      drain_q, drain_d;
    logic               zero_done_q, zero_done_d;
    logic               err_q, err_d;
    logic [AGD_LAT-1:0] vld_dly_q;
    logic [AGD_LAT-1:0] lst_dly_q;

    logic [ROW_LEN:0]   row_end, col_end;
    logic               range_ok, size_zero, beat, last_beat;
    logic [ROW_LEN-1:0] row_out, col_out;

    always_comb begin
        row_end   = {1'b0, bus.req_row} + {1'b0, bus.req_nrow};
        col_end   = {1'b0, bus.req_col} + {1'b0, bus.req_ncol};
        range_ok  = (row_end <= DIM_W) && (col_end <= DIM_W);
        size_zero = (bus.req_nrow == '0) || (bus.req_ncol == '0);
        beat      = (state_q == StRun) && !bus.hold;
        last_beat = (row_q == row_last_q) && (col_q == col_last_q);
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        col_first_d = col_first_q;
        row_last_d  = row_last_q;
        col_last_d  = col_last_q;
        drain_d     = drain_q;
        zero_done_d = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (!range_ok) begin
                        err_d = 1'b1;
                    end else if (size_zero) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d     = StRun;
                        row_d       = bus.req_row;
                        col_d       = bus.req_col;
                        col_first_d = bus.req_col;
                        row_last_d  = bus.req_row + bus.req_nrow - ROW_LEN'(1);
                        col_last_d  = bus.req_col + bus.req_ncol - ROW_LEN'(1);
                    end
                end
            end
            StRun: begin
                if (beat) begin
                    if (last_beat) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end else if (col_q == col_last_q) begin
                        col_d = col_first_q;
                        row_d = row_q + ROW_LEN'(1);
                    end else begin
                        col_d = col_q + ROW_LEN'(1);
                    end
                end
            end
            StDrain: begin
                // Wait out the address generator so done lines up with the last address.
                if (drain_q == DRAIN_LAST) begin
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            col_first_q <= '0;
            row_last_q  <= '0;
            col_last_q  <= '0;
            drain_q     <= '0;
            zero_done_q <= 1'b0;
            err_q       <= 1'b0;
            vld_dly_q   <= '0;
            lst_dly_q   <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            col_first_q  <= col_first_d;
            row_last_q   <= row_last_d;
            col_last_q   <= col_last_d;
            drain_q      <= drain_d;
            zero_done_q  <= zero_done_d;
            err_q        <= err_d;
            vld_dly_q[0] <= beat;
            lst_dly_q[0] <= beat && last_beat;
            for (int i = 1; i < AGD_LAT; i++) begin
                vld_dly_q[i] <= vld_dly_q[i-1];
                lst_dly_q[i] <= lst_dly_q[i-1];
            end
        end
    end

`ifdef CB_SYM_SWAP_EN
    always_comb begin
        row_out = (col_q > row_q) ? col_q : row_q;
        col_out = (col_q > row_q) ? row_q : col_q;
    end
`else
    always_comb begin
        row_out = row_q;
        col_out = col_q;
    end
`endif

    // Outputs are forced quiet while reset is asserted, not just after it.
    assign bus.req_ready  = (state_q == StIdle) && !sys_rst;
    assign bus.rc_valid   = beat && !sys_rst;
    assign bus.CB_row     = sys_rst ? '0 : row_out;
    assign bus.CB_col     = sys_rst ? '0 : col_out;
    assign bus.addr_valid = vld_dly_q[AGD_LAT-1] && !sys_rst;
    assign bus.addr_last  = lst_dly_q[AGD_LAT-1] && !sys_rst;
    assign bus.done       = !sys_rst &&
                            ((vld_dly_q[AGD_LAT-1] && lst_dly_q[AGD_LAT-1]) || zero_done_q);
    assign bus.req_err    = err_q && !sys_rst;
endmodule

// File: tb/tb_cb_rc_gen.sv
// Bench for cb_rc_gen: per-cycle timeline model built from the request rules, checked every cycle,
// plus directed scenarios with hand-computed cycle offsets.
module tb_cb_rc_gen;
    localparam int ROW_LEN      = 10;
    localparam int MAX_LANDMARK = 500;
    localparam int AGD_LAT      = 5;
    localparam int DIM          = 1003;
    localparam int N            = 1024;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;

    cb_rc_gen_if #(.ROW_LEN(ROW_LEN)) bus ();

    cb_rc_gen #(
        .ROW_LEN     (ROW_LEN),
        .MAX_LANDMARK(MAX_LANDMARK),
        .AGD_LAT     (AGD_LAT)
    ) dut (
        .clk    (clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected timeline, indexed by absolute cycle number.
    bit exp_rc[N], exp_av[N], exp_al[N], exp_done[N], exp_err[N], exp_rdy[N], exp_rst[N];
    bit hold_arr[N];
    int exp_row[N], exp_col[N];

    int n_chk = 0, n_pass = 0;
    int free_at = 0;
    int nb, done_n, done_cyc, err_n, err_cyc, av_n;
    int beat_cyc[64], beat_r[64], beat_c[64];

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    endtask

    always @(negedge clk) begin
        if (exp_rst[cyc]) begin
            chk("rst_rc_valid", int'(bus.rc_valid), 0);
            chk("rst_addr_valid", int'(bus.addr_valid), 0);
            chk("rst_addr_last", int'(bus.addr_last), 0);
            chk("rst_done", int'(bus.done), 0);
            chk("rst_req_err", int'(bus.req_err), 0);
            chk("rst_req_ready", int'(bus.req_ready), 0);
            chk("rst_cb_row", int'(bus.CB_row), 0);
            chk("rst_cb_col", int'(bus.CB_col), 0);
        end else if (cyc > 0) begin
            chk("rc_valid", int'(bus.rc_valid), int'(exp_rc[cyc]));
            if (exp_rc[cyc]) begin
                chk("cb_row", int'(bus.CB_row), exp_row[cyc]);
                chk("cb_col", int'(bus.CB_col), exp_col[cyc]);
            end
            chk("addr_valid", int'(bus.addr_valid), int'(exp_av[cyc]));
            chk("addr_last", int'(bus.addr_last), int'(exp_al[cyc]));
            chk("done", int'(bus.done), int'(exp_done[cyc]));
            chk("req_err", int'(bus.req_err), int'(exp_err[cyc]));
            chk("req_ready", int'(bus.req_ready), int'(exp_rdy[cyc]));
        end
        if (bus.rc_valid && nb < 64) begin
            beat_cyc[nb] = cyc;
            beat_r[nb]   = int'(bus.CB_row);
            beat_c[nb]   = int'(bus.CB_col);
            nb++;
        end
        if (bus.addr_valid) av_n++;
        if (bus.done) begin done_n++; done_cyc = cyc; end
        if (bus.req_err) begin err_n++; err_cyc = cyc; end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.hold = hold_arr[cyc];
    endtask

    // Lay out the whole life of a request accepted at cycle h.
    task automatic plan(input int h, input int r, input int c, input int nr, input int nc);
        int t;
        int tl;
        int er;
        int ec;
        tl = h;
        if (r + nr > DIM || c + nc > DIM) begin
            exp_err[h+1] = 1'b1;
            free_at = h + 1;
        end else if (nr == 0 || nc == 0) begin
            exp_done[h+1] = 1'b1;
            free_at = h + 1;
        end else begin
            t = h + 1;
            for (int i = 0; i < nr; i++) begin
                for (int j = 0; j < nc; j++) begin
                    while (hold_arr[t]) t++;
                    er = r + i;
                    ec = c + j;
`ifdef CB_SYM_SWAP_EN
                    if (ec > er) begin
                        er = c + j;
                        ec = r + i;
                    end
`endif
                    exp_rc[t] = 1'b1;
                    exp_row[t] = er;
                    exp_col[t] = ec;
                    exp_av[t+AGD_LAT] = 1'b1;
                    if (i == nr - 1 && j == nc - 1) begin
                        exp_al[t+AGD_LAT] = 1'b1;
                        tl = t;
                    end
                    t++;
                end
            end
            exp_done[tl+AGD_LAT] = 1'b1;
            for (int k = h + 1; k <= tl + AGD_LAT; k++) exp_rdy[k] = 1'b0;
            free_at = tl + AGD_LAT + 1;
        end
    endtask

    task automatic issue(input int r, input int c, input int nr, input int nc, output int h);
        h = (cyc > free_at) ? cyc : free_at;
        bus.req_valid = 1'b1;
        bus.req_row   = ROW_LEN'(r);
        bus.req_col   = ROW_LEN'(c);
        bus.req_nrow  = ROW_LEN'(nr);
        bus.req_ncol  = ROW_LEN'(nc);
        plan(h, r, c, nr, nc);
        while (cyc <= h) tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic do_reset();
        int k;
        k = cyc;
        sys_rst = 1'b1;
        for (int t = k; t < N; t++) begin
            exp_rc[t] = 1'b0; exp_av[t] = 1'b0; exp_al[t] = 1'b0;
            exp_done[t] = 1'b0; exp_err[t] = 1'b0; exp_rst[t] = 1'b0;
            exp_rdy[t] = 1'b1;
        end
        exp_rst[k] = 1'b1;
        free_at = k + 1;
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc < free_at) tick();
        repeat (2) tick();
    endtask

    task automatic start();
        nb = 0; done_n = 0; err_n = 0; av_n = 0; done_cyc = -1; err_cyc = -1;
    endtask

    int h, h2;
    int sr, sc;

    initial begin
        for (int t = 0; t < N; t++) begin
            exp_rc[t] = 1'b0; exp_av[t] = 1'b0; exp_al[t] = 1'b0; exp_done[t] = 1'b0;
            exp_err[t] = 1'b0; exp_rst[t] = 1'b0; exp_rdy[t] = 1'b1; hold_arr[t] = 1'b0;
            exp_row[t] = 0; exp_col[t] = 0;
        end
        exp_rst[0] = 1'b1;
        exp_rst[1] = 1'b1;
        free_at = 2;
        bus.req_valid = 1'b0; bus.req_row = '0; bus.req_col = '0;
        bus.req_nrow = '0; bus.req_ncol = '0; bus.hold = 1'b0;
        start();
        tick();
        tick();
        sys_rst = 1'b0;

        // Plain 2x3 block.
        wait_idle(); start();
        issue(8, 0, 2, 3, h);
        wait_idle();
        chk("s1_beats", nb, 6);
        chk("s1_first_beat_cyc", beat_cyc[0] - h, 1);
        chk("s1_last_row", beat_r[5], 9);
        chk("s1_last_col", beat_c[5], 2);
        chk("s1_done_cyc", done_cyc - h, 11);

        // Same block with a two-cycle stall.
        wait_idle(); start();
        hold_arr[cyc+2] = 1'b1;
        hold_arr[cyc+3] = 1'b1;
        issue(8, 0, 2, 3, h);
        wait_idle();
        chk("s2_beats", nb, 6);
        chk("s2_second_beat_cyc", beat_cyc[1] - h, 4);
        chk("s2_done_cyc", done_cyc - h, 13);

        // Row overflow rejected.
        wait_idle(); start();
        issue(1000, 0, 4, 1, h);
        wait_idle();
        chk("s3_err_cyc", err_cyc - h, 1);
        chk("s3_beats", nb, 0);
        chk("s3_done_n", done_n, 0);

        // Exactly reaching DIM is legal.
        wait_idle(); start();
        issue(1000, 0, 3, 1, h);
        wait_idle();
        chk("s4_beats", nb, 3);
        chk("s4_last_row", beat_r[2], 1002);
        chk("s4_done_n", done_n, 1);

        // Zero-height block completes immediately.
        wait_idle(); start();
        issue(5, 5, 0, 4, h);
        wait_idle();
        chk("s5_done_cyc", done_cyc - h, 1);
        chk("s5_beats", nb, 0);

        // Column overflow rejected.
        wait_idle(); start();
        issue(0, 1000, 1, 4, h);
        wait_idle();
        chk("s6_err_n", err_n, 1);
        chk("s6_beats", nb, 0);

        // Upper-triangular single element.
        wait_idle(); start();
        issue(2, 5, 1, 1, h);
        wait_idle();
`ifdef CB_SYM_SWAP_EN
        sr = 5; sc = 2;
`else
        sr = 2; sc = 5;
`endif
        chk("s7_row", beat_r[0], sr);
        chk("s7_col", beat_c[0], sc);

        // Second request presented while busy waits for IDLE.
        wait_idle(); start();
        issue(3, 3, 2, 2, h);
        issue(0, 0, 1, 2, h2);
        wait_idle();
        chk("s8_accept_cyc", h2 - h, 10);
        chk("s8_second_beat_cyc", beat_cyc[4] - h, 11);
        chk("s8_beats", nb, 6);
        chk("s8_done_n", done_n, 2);

        // Scattered stalls on a 3x4 block.
        wait_idle(); start();
        hold_arr[cyc+1] = 1'b1;
        hold_arr[cyc+4] = 1'b1;
        hold_arr[cyc+5] = 1'b1;
        hold_arr[cyc+9] = 1'b1;
        issue(100, 200, 3, 4, h);
        wait_idle();
        chk("s9_beats", nb, 12);
        chk("s9_done_cyc", done_cyc - h, 21);

        // Reset on the third beat aborts everything.
        wait_idle(); start();
        issue(8, 0, 2, 3, h);
        while (cyc < h + 3) tick();
        do_reset();
        repeat (15) tick();
        chk("s10_beats", nb, 2);
        chk("s10_done_n", done_n, 0);
        chk("s10_addr_valid_n", av_n, 0);

        // Still usable after the abort.
        wait_idle(); start();
        issue(0, 0, 1, 1, h);
        wait_idle();
        chk("s11_done_cyc", done_cyc - h, 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
